// File: rtl/romulus_stream_absorb.sv
// romulus_stream_absorb
// Absorbs one 128-bit Romulus block from a BUSWIDTH-wide beat stream,
// applies the rho function bytewise, pads short blocks with their length
// byte and hands the state to the tweakable block cipher.
//
// Handshakes: a beat moves on pdi when pdi_valid & pdi_ready are both high
// on a rising clk edge; pdi_data/pdi_bytes/pdi_last/ad/decrypt are sampled
// on that edge only. On pdo the producer (this block) holds pdo_data stable
// while pdo_valid & !pdo_ready; the beat is consumed on pdo_valid & pdo_ready.
// tbc_start is a single-cycle pulse; tbc_done qualifies state_i and is only
// honoured while waiting for the cipher.
module romulus_stream_absorb #(
  parameter int BUSWIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BUSWIDTH-1:0]              pdi_data,
  input  logic [$clog2(BUSWIDTH/8):0]      pdi_bytes,
  input  logic                             pdi_last,
  input  logic                             pdi_valid,
  output logic                             pdi_ready,
  input  logic                             ad,
  input  logic                             decrypt,
  output logic [BUSWIDTH-1:0]              pdo_data,
  output logic                             pdo_valid,
  input  logic                             pdo_ready,
  output logic                             tbc_start,
  input  logic                             tbc_done,
  input  logic [127:0]                     state_i,
  output logic [127:0]                     state_o,
  output logic [4:0]                       block_len,
  output logic [1:0]                       fsm_state
);

  localparam int NBEATS = 128 / BUSWIDTH;
  localparam int NBYTES = BUSWIDTH / 8;
  localparam int BCW    = $clog2(NBYTES) + 1;
  localparam int CNTW   = $clog2(NBEATS) + 1;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_PAD      = 2'd1,
    ST_TBC_WAIT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [127:0]        state_reg;
  logic [127:0]        state_next;
  logic [4:0]          len_q;
  logic [4:0]          len_sum;
  logic [CNTW-1:0]     cnt_q;
  logic                short_q;
  logic                pdo_valid_q;
  logic [BUSWIDTH-1:0] pdo_data_q;
  logic                tbc_start_q;

  logic                accept;
  logic                block_end;
  logic [BCW-1:0]      eff_bytes;
  logic [BUSWIDTH-1:0] cur_slice;
  logic [BUSWIDTH-1:0] new_slice;
  logic [BUSWIDTH-1:0] out_slice;
  logic [7:0]          s_b;
  logic [7:0]          i_b;
  logic [7:0]          g_b;
  logic [7:0]          m_b;

  assign state_o   = state_reg;
  assign block_len = len_q;
  assign pdo_valid = pdo_valid_q;
  assign pdo_data  = pdo_data_q;
  assign tbc_start = tbc_start_q;
  assign fsm_state = state_q;

  // New beats are taken only while loading and when the pdo register is free
  assign pdi_ready = (state_q == ST_LOAD) & (~pdo_valid_q | pdo_ready);
  assign accept    = pdi_valid & pdi_ready;
  assign block_end = pdi_last | (cnt_q == CNTW'(NBEATS - 1));
  assign len_sum   = len_q + 5'(eff_bytes);

  // Valid byte count: clamp oversize counts, force zero after a short beat
  always_comb begin
    eff_bytes = pdi_bytes;
    if (short_q) begin
      eff_bytes = '0;
    end else if (pdi_bytes > BCW'(NBYTES)) begin
      eff_bytes = BCW'(NBYTES);
    end
  end

  // Rho on the state slice addressed by the beat counter
  always_comb begin
    cur_slice = '0;
    new_slice = '0;
    out_slice = '0;
    s_b       = '0;
    i_b       = '0;
    g_b       = '0;
    m_b       = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (cnt_q == CNTW'(b)) begin
        cur_slice = state_reg[127 - b*BUSWIDTH -: BUSWIDTH];
      end
    end
    for (int k = 0; k < NBYTES; k++) begin
      s_b = cur_slice[BUSWIDTH-1-8*k -: 8];
      i_b = pdi_data[BUSWIDTH-1-8*k -: 8];
      g_b = {s_b[0] ^ s_b[7], s_b[7:1]};
      m_b = decrypt ? (i_b ^ g_b) : i_b;
      if (BCW'(k) < eff_bytes) begin
        new_slice[BUSWIDTH-1-8*k -: 8] = s_b ^ m_b;
        out_slice[BUSWIDTH-1-8*k -: 8] = decrypt ? m_b : (i_b ^ g_b);
      end else begin
        new_slice[BUSWIDTH-1-8*k -: 8] = s_b;
        out_slice[BUSWIDTH-1-8*k -: 8] = 8'h00;
      end
    end
  end

  // Next FSM state and next state-register contents
  always_comb begin
    state_d    = state_q;
    state_next = state_reg;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          for (int b = 0; b < NBEATS; b++) begin
            if (cnt_q == CNTW'(b)) begin
              state_next[127 - b*BUSWIDTH -: BUSWIDTH] = new_slice;
            end
          end
          if (block_end) begin
            state_d = (len_sum == 5'd16) ? ST_TBC_WAIT : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        // Zero padding bytes leave the state alone; only the length byte lands
        state_next[7:0] = state_reg[7:0] ^ {3'b000, len_q};
        state_d         = ST_TBC_WAIT;
      end
      ST_TBC_WAIT: begin
        if (tbc_done) begin
          state_next = state_i;
          state_d    = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // FSM, state register, block length and beat bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      state_reg   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      short_q     <= 1'b0;
      tbc_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      state_reg   <= state_next;
      tbc_start_q <= (state_d == ST_TBC_WAIT) && (state_q != ST_TBC_WAIT);
      if (accept) begin
        len_q <= len_sum;
        cnt_q <= cnt_q + CNTW'(1);
        if (eff_bytes < BCW'(NBYTES)) begin
          short_q <= 1'b1;
        end
      end
      if ((state_q == ST_TBC_WAIT) && tbc_done) begin
        len_q   <= '0;
        cnt_q   <= '0;
        short_q <= 1'b0;
      end
    end
  end

  // Output beat register: a new message beat wins over a downstream take
  always_ff @(posedge clk) begin
    if (rst) begin
      pdo_valid_q <= 1'b0;
      pdo_data_q  <= '0;
    end else if (accept && !ad) begin
      pdo_valid_q <= 1'b1;
      pdo_data_q  <= out_slice;
    end else if (pdo_ready) begin
      pdo_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_romulus_stream_absorb.sv
// Directed bench for romulus_stream_absorb at BUSWIDTH=32: a table of
// beats with hand-computed pdo/state results, then hand-written sequences
// for backpressure and reset while waiting on the cipher.
module tb_romulus_stream_absorb;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] pdi_data;
  logic [2:0]    pdi_bytes;
  logic          pdi_last;
  logic          pdi_valid;
  logic          pdi_ready;
  logic          ad;
  logic          decrypt;
  logic [BW-1:0] pdo_data;
  logic          pdo_valid;
  logic          pdo_ready;
  logic          tbc_start;
  logic          tbc_done;
  logic [127:0]  state_i;
  logic [127:0]  state_o;
  logic [4:0]    block_len;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]  data;
    logic [2:0]   nbytes;
    logic         last;
    logic         ad;
    logic         dec;
    logic [31:0]  exp_pdo;
    logic         exp_pv;
    logic         blk_end;
    logic         pad;
    logic [127:0] exp_state;
    logic [4:0]   exp_len;
    logic [127:0] next_st;
  } vec_t;

  vec_t tbl[$];

  // clock and reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  romulus_stream_absorb #(.BUSWIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdi_data  (pdi_data),
    .pdi_bytes (pdi_bytes),
    .pdi_last  (pdi_last),
    .pdi_valid (pdi_valid),
    .pdi_ready (pdi_ready),
    .ad        (ad),
    .decrypt   (decrypt),
    .pdo_data  (pdo_data),
    .pdo_valid (pdo_valid),
    .pdo_ready (pdo_ready),
    .tbc_start (tbc_start),
    .tbc_done  (tbc_done),
    .state_i   (state_i),
    .state_o   (state_o),
    .block_len (block_len),
    .fsm_state (fsm_state)
  );

  // scoreboard compare
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_beat(input logic [31:0] d, input logic [2:0] nb, input logic l,
                                   input logic a, input logic dc, input logic [31:0] ep,
                                   input logic epv);
    vec_t v;
    v           = '0;
    v.data      = d;
    v.nbytes    = nb;
    v.last      = l;
    v.ad        = a;
    v.dec       = dc;
    v.exp_pdo   = ep;
    v.exp_pv    = epv;
    return v;
  endfunction

  function automatic vec_t mk_end(input logic [31:0] d, input logic [2:0] nb, input logic l,
                                  input logic a, input logic dc, input logic [31:0] ep,
                                  input logic epv, input logic pd, input logic [127:0] es,
                                  input logic [4:0] el, input logic [127:0] ns);
    vec_t v;
    v           = mk_beat(d, nb, l, a, dc, ep, epv);
    v.blk_end   = 1'b1;
    v.pad       = pd;
    v.exp_state = es;
    v.exp_len   = el;
    v.next_st   = ns;
    return v;
  endfunction

  // driver: offer one beat, wait (bounded) for acceptance, return #1 after the edge
  task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic l,
                           input logic a, input logic dc);
    int n;
    @(negedge clk);
    pdi_data  = d;
    pdi_bytes = nb;
    pdi_last  = l;
    ad        = a;
    decrypt   = dc;
    pdi_valid = 1'b1;
    n = 0;
    while (!pdi_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pdi_ready_wait", pdi_ready, 1'b1);
    @(posedge clk);
    #1;
    pdi_valid = 1'b0;
  endtask

  // driver: cipher returns a new state
  task automatic do_done(input logic [127:0] v);
    @(negedge clk);
    state_i  = v;
    tbc_done = 1'b1;
    @(posedge clk);
    #1;
    tbc_done = 1'b0;
    chk("done_state", state_o, v);
    chk("done_len", block_len, 5'd0);
    chk("done_fsm", fsm_state, 2'd0);
  endtask

  initial begin
    rst       = 1'b1;
    pdi_data  = '0;
    pdi_bytes = '0;
    pdi_last  = 1'b0;
    pdi_valid = 1'b0;
    ad        = 1'b0;
    decrypt   = 1'b0;
    pdo_ready = 1'b1;
    tbc_done  = 1'b0;
    state_i   = '0;

    // A: full encrypt block from zero state, pdo mirrors pdi, no PAD
    tbl.push_back(mk_beat(32'h00010203, 3'd4, 1'b0, 1'b0, 1'b0, 32'h00010203, 1'b1));
    tbl.push_back(mk_beat(32'h04050607, 3'd4, 1'b0, 1'b0, 1'b0, 32'h04050607, 1'b1));
    tbl.push_back(mk_beat(32'h08090A0B, 3'd4, 1'b0, 1'b0, 1'b0, 32'h08090A0B, 1'b1));
    tbl.push_back(mk_end(32'h0C0D0E0F, 3'd4, 1'b1, 1'b0, 1'b0, 32'h0C0D0E0F, 1'b1, 1'b0,
                         128'h000102030405060708090A0B0C0D0E0F, 5'd16, 128'h0));
    // B: partial 3-byte block, pad length 3
    tbl.push_back(mk_end(32'hAABBCCDD, 3'd3, 1'b1, 1'b0, 1'b0, 32'hAABBCC00, 1'b1, 1'b1,
                         128'hAABBCC00_00000000_00000000_00000003, 5'd3,
                         128'h01010101_01010101_01010101_01010101));
    // C: decrypt zero beat over state 0x01.. -> M=0x80, state 0x81, pad 4
    tbl.push_back(mk_end(32'h00000000, 3'd4, 1'b1, 1'b0, 1'b1, 32'h80808080, 1'b1, 1'b1,
                         128'h81818181_01010101_01010101_01010105, 5'd4, 128'h0));
    // D: AD block ended implicitly on the 4th beat, no output
    tbl.push_back(mk_beat(32'h11111111, 3'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk_beat(32'h22222222, 3'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk_beat(32'h33333333, 3'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
    tbl.push_back(mk_end(32'h44444444, 3'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                         128'h11111111_22222222_33333333_44444444, 5'd16, 128'h0));
    // E: oversize count clamped, then a short beat, then empty beats
    tbl.push_back(mk_beat(32'h12345678, 3'd7, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1));
    tbl.push_back(mk_beat(32'h9ABCDEF0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h9ABC0000, 1'b1));
    tbl.push_back(mk_beat(32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1));
    tbl.push_back(mk_end(32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1,
                         128'h12345678_9ABC0000_00000000_00000006, 5'd6,
                         128'h0));
    // F: empty block still pads (XOR 0) and goes to the cipher
    tbl.push_back(mk_end(32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1,
                         128'h0, 5'd0,
                         128'h03030303_03030303_03030303_03030303));
    // G: encrypt over state 0x03.. -> G=0x81
    tbl.push_back(mk_end(32'h00FF1234, 3'd4, 1'b1, 1'b0, 1'b0, 32'h817E93B5, 1'b1, 1'b1,
                         128'h03FC1137_03030303_03030303_03030307, 5'd4, 128'h0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_o, 128'h0);
    chk("rst_len", block_len, 5'd0);
    chk("rst_pdo_valid", pdo_valid, 1'b0);
    chk("rst_pdo_data", pdo_data, 32'h0);
    chk("rst_tbc_start", tbc_start, 1'b0);
    chk("rst_fsm", fsm_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven blocks
    for (int i = 0; i < tbl.size(); i++) begin
      send_beat(tbl[i].data, tbl[i].nbytes, tbl[i].last, tbl[i].ad, tbl[i].dec);
      chk($sformatf("v%0d_pdo_valid", i), pdo_valid, tbl[i].exp_pv);
      if (tbl[i].exp_pv) chk($sformatf("v%0d_pdo_data", i), pdo_data, tbl[i].exp_pdo);
      if (tbl[i].blk_end) begin
        if (!tbl[i].pad) begin
          chk($sformatf("v%0d_tbc_start_nopad", i), tbc_start, 1'b1);
          chk($sformatf("v%0d_fsm_wait", i), fsm_state, 2'd2);
        end else begin
          chk($sformatf("v%0d_fsm_pad", i), fsm_state, 2'd1);
          chk($sformatf("v%0d_no_early_start", i), tbc_start, 1'b0);
          @(posedge clk);
          #1;
          chk($sformatf("v%0d_tbc_start_pad", i), tbc_start, 1'b1);
        end
        chk($sformatf("v%0d_state", i), state_o, tbl[i].exp_state);
        chk($sformatf("v%0d_len", i), block_len, tbl[i].exp_len);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_start_single", i), tbc_start, 1'b0);
        chk($sformatf("v%0d_still_wait", i), fsm_state, 2'd2);
        do_done(tbl[i].next_st);
      end
    end

    // backpressure: pdo stalled after the first beat
    @(negedge clk);
    pdo_ready = 1'b0;
    send_beat(32'h01020304, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("bp_pv1", pdo_valid, 1'b1);
    chk("bp_pd1", pdo_data, 32'h01020304);
    @(negedge clk);
    chk("bp_ready_low", pdi_ready, 1'b0);
    pdi_data  = 32'h05060708;
    pdi_bytes = 3'd4;
    pdi_last  = 1'b0;
    pdi_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", pdo_data, 32'h01020304);
      chk("bp_hold_valid", pdo_valid, 1'b1);
      chk("bp_hold_len", block_len, 5'd4);
    end
    @(negedge clk);
    pdo_ready = 1'b1;
    #1;
    chk("bp_ready_back", pdi_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_pd2", pdo_data, 32'h05060708);
    chk("bp_len2", block_len, 5'd8);
    @(negedge clk);
    pdi_data = 32'h090A0B0C;
    @(posedge clk);
    #1;
    chk("bp_pd3", pdo_data, 32'h090A0B0C);
    chk("bp_len3", block_len, 5'd12);
    @(negedge clk);
    pdi_data = 32'h0D0E0F10;
    pdi_last = 1'b1;
    @(posedge clk);
    #1;
    pdi_valid = 1'b0;
    pdi_last  = 1'b0;
    chk("bp_pd4", pdo_data, 32'h0D0E0F10);
    chk("bp_len4", block_len, 5'd16);
    chk("bp_start", tbc_start, 1'b1);
    chk("bp_state", state_o, 128'h01020304_05060708_090A0B0C_0D0E0F10);
    do_done(128'h0);

    // reset while waiting on the cipher, with tbc_done in the same cycle
    send_beat(32'hCAFEF00D, 3'd4, 1'b0, 1'b1, 1'b0);
    send_beat(32'hCAFEF00D, 3'd4, 1'b0, 1'b1, 1'b0);
    send_beat(32'hCAFEF00D, 3'd4, 1'b0, 1'b1, 1'b0);
    send_beat(32'hCAFEF00D, 3'd4, 1'b0, 1'b1, 1'b0);
    chk("rw_start", tbc_start, 1'b1);
    chk("rw_fsm_wait", fsm_state, 2'd2);
    @(negedge clk);
    rst      = 1'b1;
    tbc_done = 1'b1;
    state_i  = {128{1'b1}};
    @(posedge clk);
    #1;
    chk("rw_state", state_o, 128'h0);
    chk("rw_fsm", fsm_state, 2'd0);
    chk("rw_len", block_len, 5'd0);
    chk("rw_start_clr", tbc_start, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    tbc_done = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_no_start", tbc_start, 1'b0);
    chk("rw_fsm_load", fsm_state, 2'd0);
    chk("rw_state_hold", state_o, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
